sm2_modadd_arb: RTL and testbench
=================================

# sm2_modadd_arb

Round-robin arbiter and sequencer that shares one SM2 mod-p add/sub unit (`mod_add_p`) among `NREQ` requesters, e.g. the point-add and point-double controllers. It latches the winning requester's operands and issues a single-cycle `start` to the unit. It then waits for `done`, captures the result and returns it to the winner with a one-cycle `ack`. It sits between the SM2 scalar-multiply controllers and the single `mod_add_p` instance.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 15: maximum cycles spent in WAIT before abort; used only with `SM2_MODADD_ARB_TIMEOUT_EN`.

- `clk` in 1: single clock; all logic is on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `req` in NREQ: level request per requester.
- `req_a` in 256*NREQ: operand a; requester i uses bits [256*i+255:256*i].
- `req_b` in 256*NREQ: operand b, packed the same way as `req_a`.
- `req_minus` in NREQ: 1 selects a−b mod p; 0 selects a+b mod p.
- `ack` out NREQ: one-hot, one-cycle pulse marking completion for requester i.
- `result` out 256: result for the acked requester; held until the next capture.
- `err` out 1: valid with `ack`; 1 means the operation timed out.
- `ma_start` out 1: start pulse to the unit.
- `ma_a` out 256: operand a to the unit.
- `ma_b` out 256: operand b to the unit.
- `ma_minus` out 1: add/sub select to the unit.
- `ma_c` in 256: result from the unit.
- `ma_done` in 1: done strobe from the unit.

## Operation
- States, one-hot: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If `req` is nonzero, select the first asserted requester at or after `ptr`, searching upward and wrapping from NREQ−1 to 0.
  - Latch the winner's a, b and minus into `op_a`, `op_b`, `op_m`, and its index into `gnt`.
  - Set `ptr` to gnt+1 mod NREQ, then go to ISSUE.
  - If `req` is zero, stay in IDLE.
- **ISSUE**
  - `ma_start`=1 for exactly this cycle.
  - `ma_a`/`ma_b`/`ma_minus` are driven from `op_*` in this cycle and all other cycles.
  - Go to WAIT.
- **WAIT**
  - Stay until `ma_done`=1.
  - On that edge: `result` ← `ma_c`, `err_r` ← 0, go to RESP. `ma_c` is only valid in the `done` cycle and must be captured there.
- **RESP**
  - `ack[gnt]`=1 and `err`=`err_r` for this cycle only; go to IDLE.
- Requester rules:
  - Hold `req` and operands stable from assertion until the `ack` cycle.
  - Deassert `req` on the edge that samples `ack`. A `req` still high in the following IDLE cycle is a new request.
- Requests arriving while the arbiter is not in IDLE wait; none are dropped.
- A requester dropping `req` before `ack` is illegal. Its latched operation still completes and is acked.
- `ma_done` outside WAIT is ignored.
- The unit returns p, not 0, for a−b when a==b. The arbiter passes this through unchanged; callers own that case.

## Timing
- Reset values: `ack`=0, `result`=0, `err`=0, `ma_start`=0, `ma_a`=0, `ma_b`=0, `ma_minus`=0. State is IDLE, `ptr`=0, `gnt`=0.
- Cycle of the pipeline with the unit's 4-cycle start-to-done:
  - 0: IDLE, request sampled.
  - 1: ISSUE.
  - 2–4: WAIT.
  - 5: WAIT with `ma_done`; result captured.
  - 6: RESP, `ack`.
- Request-to-`ack` latency is 6 cycles. Back-to-back operations are issued every 7 cycles.
- `ma_start` is never high in two consecutive cycles. It is never asserted again before `ma_done` of the previous operation.
- Reset mid-operation forces all state and outputs to reset values immediately. No `ack` is produced for the aborted operation. The unit shares `rstn` and resets with the arbiter.

## Configuration
- `SM2_MODADD_ARB_TIMEOUT_EN` defined:
  - A 4-bit-or-wider counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT` without `ma_done`: `result` ← 0, `err_r` ← 1, go to RESP.
  - If `ma_done` arrives in the same cycle the counter hits `TIMEOUT`, `done` wins and `err`=0.
- Not defined: no counter; WAIT waits indefinitely and `err` is tied to 0.

## Test plan
- Add wrap: req[0], a=p−1, b=2, minus=0 → `ack[0]` at cycle 6 with `result`=1, `err`=0; `ma_start` high for exactly 1 cycle.
- Subtract with borrow: req[1], a=1, b=2, minus=1 → `result`=p−1 (FFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFE).
- Round-robin fairness:
  - Stimulus: req=4'b1111 held, each requester re-requesting after its `ack`, distinct operands per requester.
  - Required: `ack` order 0,1,2,3,0; `ack` pulses 7 cycles apart; each result matches its own operands.
- Ignored strobe: `ma_done` forced high during IDLE with no request → no state change, no `ack`.
- Timeout (macro on, `TIMEOUT`=15): unit stubbed to never assert `done` → `ack` with `err`=1 and `result`=0 at cycle 1+15+1. A following normal request completes with `err`=0.
- Reset mid-operation: `rstn` pulsed low during WAIT → all outputs 0 asynchronously, no `ack`. With req=4'b0110 after release, requester 1 is served first (`ptr`=0).

Source files
------------

// File: rtl/sm2_modadd_arb_if.sv
// Bundle between the arbiter, its requesters and the shared mod_add_p unit.
// master: requesters plus unit side; slave: the arbiter.
interface sm2_modadd_arb_if #(
  parameter int unsigned NREQ = 4
) ();
  logic [NREQ-1:0]     req;
  logic [256*NREQ-1:0] req_a;
  logic [256*NREQ-1:0] req_b;
  logic [NREQ-1:0]     req_minus;
  logic [NREQ-1:0]     ack;
  logic [255:0]        result;
  logic                err;

  logic                ma_start;
  logic [255:0]        ma_a;
  logic [255:0]        ma_b;
  logic                ma_minus;
  logic [255:0]        ma_c;
  logic                ma_done;

  modport master (
    output req, req_a, req_b, req_minus, ma_c, ma_done,
    input  ack, result, err, ma_start, ma_a, ma_b, ma_minus
  );

  modport slave (
    input  req, req_a, req_b, req_minus, ma_c, ma_done,
    output ack, result, err, ma_start, ma_a, ma_b, ma_minus
  );
endinterface

// File: rtl/sm2_modadd_arb.sv
// Round-robin arbiter sharing one SM2 mod-p add/sub unit among NREQ requesters.
// Optional WAIT timeout enabled by defining SM2_MODADD_ARB_TIMEOUT_EN.
module sm2_modadd_arb #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input logic             clk_i,
  input logic             rst_ni,
  sm2_modadd_arb_if.slave bus_io
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("sm2_modadd_arb: NREQ must be in 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("sm2_modadd_arb: TIMEOUT must be at least 1");
  end

  typedef enum logic [3:0] {
    StIdle  = 4'b0001,
    StIssue = 4'b0010,
    StWait  = 4'b0100,
    StResp  = 4'b1000
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] gnt_q, gnt_d;
  logic [255:0]    op_a_q, op_a_d;
  logic [255:0]    op_b_q, op_b_d;
  logic            op_m_q, op_m_d;
  logic [255:0]    result_q, result_d;

`ifdef SM2_MODADD_ARB_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_r_q, err_r_d;
`endif

  logic            found;
  logic [IdxW-1:0] win;

  // First asserted request at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && bus_io.req[(32'(ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        win   = IdxW'((32'(ptr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_m_d   = op_m_q;
    result_d = result_q;
`ifdef SM2_MODADD_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_r_d  = err_r_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (found) begin
          gnt_d   = win;
          ptr_d   = (32'(win) == NREQ - 1) ? '0 : win + 1'b1;
          op_a_d  = bus_io.req_a[32'(win)*256 +: 256];
          op_b_d  = bus_io.req_b[32'(win)*256 +: 256];
          op_m_d  = bus_io.req_minus[win];
          state_d = StIssue;
        end
      end
      StIssue: begin
`ifdef SM2_MODADD_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = StWait;
      end
      StWait: begin
        // ma_c is only valid while ma_done is high, so it is captured here.
        if (bus_io.ma_done) begin
          result_d = bus_io.ma_c;
`ifdef SM2_MODADD_ARB_TIMEOUT_EN
          err_r_d  = 1'b0;
`endif
          state_d  = StResp;
        end
`ifdef SM2_MODADD_ARB_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          result_d = '0;
          err_r_d  = 1'b1;
          state_d  = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      gnt_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_m_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_m_q   <= op_m_d;
      result_q <= result_d;
    end
  end

`ifdef SM2_MODADD_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      err_r_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      err_r_q <= err_r_d;
    end
  end
`endif

  always_comb begin
    bus_io.ack = '0;
    if (state_q == StResp) begin
      bus_io.ack[gnt_q] = 1'b1;
    end
  end

  assign bus_io.ma_start = (state_q == StIssue);
  assign bus_io.ma_a     = op_a_q;
  assign bus_io.ma_b     = op_b_q;
  assign bus_io.ma_minus = op_m_q;
  assign bus_io.result   = result_q;

`ifdef SM2_MODADD_ARB_TIMEOUT_EN
  assign bus_io.err = (state_q == StResp) && err_r_q;
`else
  assign bus_io.err = 1'b0;
`endif

  a_start_gap: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus_io.ma_start |=> !bus_io.ma_start);
  a_ack_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(bus_io.ack));

endmodule

// File: tb/tb_sm2_modadd_arb.sv
// Scoreboard bench for sm2_modadd_arb with a behavioural 4-cycle mod_add_p stand-in.
`timescale 1ns/1ps
module tb_sm2_modadd_arb;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 15;
  localparam logic [255:0] P =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
  localparam logic [255:0] PM1 =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFE;

  typedef struct {
    int           idx;
    logic [255:0] res;
    logic         err;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic stall;
  logic force_done;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  int   ack_cnt = 0;
  int   starts = 0;
  logic prev_start = 1'b0;
  exp_t sb[$];

  sm2_modadd_arb_if #(.NREQ(NREQ)) bus ();

  sm2_modadd_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Unit stand-in: done 4 cycles after start; a-b with a==b returns p.
  function automatic logic [255:0] mod_op(input logic [255:0] a, input logic [255:0] b,
                                          input logic m);
    logic [256:0] s;
    if (!m) begin
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, P}) s = s - {1'b0, P};
    end else if (a > b) begin
      s = {1'b0, a} - {1'b0, b};
    end else begin
      s = {1'b0, a} + {1'b0, P} - {1'b0, b};
    end
    return s[255:0];
  endfunction

  logic         busy;
  int           dly;
  logic [255:0] ua, ub;
  logic         um;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      dly         <= 0;
      ua          <= '0;
      ub          <= '0;
      um          <= 1'b0;
      bus.ma_done <= 1'b0;
      bus.ma_c    <= '0;
    end else begin
      bus.ma_done <= force_done;
      if (force_done) bus.ma_c <= 256'hDEAD_BEEF;
      if (bus.ma_start) begin
        busy <= !stall;
        dly  <= 0;
        ua   <= bus.ma_a;
        ub   <= bus.ma_b;
        um   <= bus.ma_minus;
      end else if (busy) begin
        dly <= dly + 1;
        if (dly == 2) begin
          bus.ma_done <= 1'b1;
          bus.ma_c    <= mod_op(ua, ub, um);
          busy        <= 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever an ack is presented.
  always @(negedge clk) begin
    exp_t           e;
    logic [NREQ-1:0] ev;
    if (rst_n) begin
      if (bus.ma_start) begin
        starts++;
        check("start_gap", 256'(prev_start), 256'(0));
      end
      prev_start = bus.ma_start;
      if (bus.ack != '0) begin
        ack_cnt++;
        if (sb.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_ack: got ack=%b expected none", bus.ack);
        end else begin
          e  = sb.pop_front();
          ev = '0;
          ev[e.idx] = 1'b1;
          check("ack_vector", 256'(bus.ack), 256'(ev));
          check("result", bus.result, e.res);
          check("err", 256'(bus.err), 256'(e.err));
          check("ack_cycle", 256'(cyc), 256'(e.cyc));
        end
      end
    end else begin
      prev_start = 1'b0;
    end
  end

  task automatic set_op(input int idx, input logic [255:0] a, input logic [255:0] b,
                        input logic m);
    bus.req_a[256*idx +: 256] = a;
    bus.req_b[256*idx +: 256] = b;
    bus.req_minus[idx]        = m;
  endtask

  // Called at a negedge (cycle 0); returns one cycle after the expected ack.
  task automatic single_op(input int idx, input logic [255:0] a, input logic [255:0] b,
                           input logic m, input logic [255:0] er, input logic ee,
                           input int lat);
    int t;
    set_op(idx, a, b, m);
    bus.req[idx] = 1'b1;
    t = cyc + lat;
    sb.push_back('{idx, er, ee, t});
    while (cyc < t) @(negedge clk);
    bus.req[idx] = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int c0, a0, s0;
    rst_n         = 1'b0;
    stall         = 1'b0;
    force_done    = 1'b0;
    bus.req       = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_minus = '0;
    repeat (2) @(negedge clk);
    check("rst_ack", 256'(bus.ack), 256'(0));
    check("rst_result", bus.result, '0);
    check("rst_err", 256'(bus.err), 256'(0));
    check("rst_ma_start", 256'(bus.ma_start), 256'(0));
    check("rst_ma_a", bus.ma_a, '0);
    check("rst_ma_b", bus.ma_b, '0);
    check("rst_ma_minus", 256'(bus.ma_minus), 256'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Add with wrap, then subtract with borrow.
    s0 = starts;
    single_op(0, PM1, 256'd2, 1'b0, 256'd1, 1'b0, 6);
    check("start_count", 256'(starts - s0), 256'(1));
    single_op(1, 256'd1, 256'd2, 1'b1, PM1, 1'b0, 6);

    // ma_done in IDLE with no request is ignored.
    a0 = ack_cnt;
    s0 = starts;
    force_done = 1'b1;
    repeat (3) @(negedge clk);
    force_done = 1'b0;
    repeat (2) @(negedge clk);
    check("strobe_no_ack", 256'(ack_cnt), 256'(a0));
    check("strobe_no_start", 256'(starts), 256'(s0));
    check("strobe_result", bus.result, PM1);
    single_op(2, 256'd5, 256'd7, 1'b0, 256'd12, 1'b0, 6);

    // Round-robin with all four requesting from ptr=0.
    do_reset();
    set_op(0, 256'h10, 256'd3, 1'b0);
    set_op(1, 256'h20, 256'd4, 1'b1);
    set_op(2, 256'h30, 256'd5, 1'b0);
    set_op(3, 256'h40, 256'd6, 1'b1);
    s0 = starts;
    bus.req = 4'b1111;
    c0 = cyc;
    sb.push_back('{0, 256'h13, 1'b0, c0 + 6});
    sb.push_back('{1, 256'h1C, 1'b0, c0 + 13});
    sb.push_back('{2, 256'h35, 1'b0, c0 + 20});
    sb.push_back('{3, 256'h3A, 1'b0, c0 + 27});
    sb.push_back('{0, 256'h13, 1'b0, c0 + 34});
    while (cyc < c0 + 34) @(negedge clk);
    bus.req = '0;
    repeat (2) @(negedge clk);
    check("rr_start_count", 256'(starts - s0), 256'(5));

    // Reset during WAIT: outputs clear at once, no ack for the aborted op.
    set_op(3, 256'h100, 256'd1, 1'b1);
    bus.req[3] = 1'b1;
    c0 = cyc;
    while (cyc < c0 + 3) @(negedge clk);
    #2;
    rst_n   = 1'b0;
    bus.req = '0;
    #1;
    check("arst_ack", 256'(bus.ack), 256'(0));
    check("arst_result", bus.result, '0);
    check("arst_err", 256'(bus.err), 256'(0));
    check("arst_ma_start", 256'(bus.ma_start), 256'(0));
    check("arst_ma_a", bus.ma_a, '0);
    check("arst_ma_b", bus.ma_b, '0);
    check("arst_ma_minus", 256'(bus.ma_minus), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    set_op(1, 256'd7, 256'd3, 1'b1);
    set_op(2, 256'd9, 256'd9, 1'b1);
    bus.req = 4'b0110;
    c0 = cyc;
    sb.push_back('{1, 256'd4, 1'b0, c0 + 6});
    sb.push_back('{2, P, 1'b0, c0 + 13});
    while (cyc < c0 + 6) @(negedge clk);
    bus.req[1] = 1'b0;
    while (cyc < c0 + 13) @(negedge clk);
    bus.req[2] = 1'b0;
    repeat (2) @(negedge clk);

`ifdef SM2_MODADD_ARB_TIMEOUT_EN
    // Stalled unit: abort after TIMEOUT WAIT cycles, then a normal op.
    stall = 1'b1;
    single_op(2, 256'd3, 256'd4, 1'b0, 256'd0, 1'b1, 1 + TIMEOUT + 1);
    stall = 1'b0;
    single_op(0, 256'd3, 256'd4, 1'b0, 256'd7, 1'b0, 6);
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", 256'(sb.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
